riv_timer_sched: RTL and testbench
==================================

// Module: riv_timer_sched
// PURPOSE
//   Round-robin scheduler that shares one down-counting timer between NUM_REQ requesters.
//   Each requester posts a timeout length in ticks. The block grants one requester at a time,
//   loads the timer and decrements it on each qualified tick. It then pulses that requester's expire.
//   Sits beside the link-layer FSMs, which need occasional, non-overlapping timeouts.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..16
//   CNT_W    16  timer width in bits; max timeout 2**CNT_W-1 ticks
// PORTS
//   clk        in   1              clock
//   rst_n      in   1              asynchronous active-low reset
//   tick       in   1              timebase strobe; timer decrements only when high
//   req_valid  in   NUM_REQ        per-requester timeout request
//   req_count  in   NUM_REQ*CNT_W  per-requester timeout, slice i = [i*CNT_W +: CNT_W]
//   req_ready  out  NUM_REQ        one-hot grant; request accepted when valid&ready
//   cancel     in   NUM_REQ        abort request from the owner of the running timer
//   expire     out  NUM_REQ        one-cycle pulse to the owner when its timeout elapses
//   busy       out  1              high whenever state != IDLE
//   active_id  out  $clog2(NUM_REQ) index of the current owner; holds the last owner when idle
// BEHAVIOUR
//   Reset (async assert, sync deassert by the upstream synchroniser):
//     state=IDLE, count=0, rr_ptr=0, active_id=0, expire=0, busy=0, req_ready=0.
//   FSM states IDLE, RUN, EXPIRE.
//   IDLE:
//     req_ready is combinational and one-hot: the first set req_valid bit searching from rr_ptr upward, wrapping.
//     req_ready is all zero when no request is pending or state != IDLE.
//     On accept of requester g: active_id<=g, rr_ptr<=(g+1)%NUM_REQ, count<=req_count[g].
//     After accept, go to EXPIRE if req_count[g]==0, else go to RUN.
//     A tick in the accept cycle is ignored.
//   RUN:
//     On tick with count==1: count<=0 and go to EXPIRE.
//     On tick with count>1: count<=count-1.
//     Without tick: hold.
//     On cancel[active_id]: go to IDLE, count<=0, no expire. Cancel takes priority over a simultaneous final tick.
//     cancel bits of non-owners are ignored in every state.
//   EXPIRE:
//     expire[active_id]=1 for exactly this one cycle. expire is a decode of the registered state; it is glitch-free.
//     Unconditionally return to IDLE next cycle. A cancel here is ignored and expire still fires.
//   Latency: a value N>0 accepted at edge E expires in the cycle after the edge that samples the Nth qualified tick.
//     A value N=0 expires in the cycle immediately after E.
//   Back-to-back: the earliest new grant is in the IDLE cycle following EXPIRE or cancel, so there is one dead cycle.
//   Fairness: each requester waits for at most NUM_REQ-1 other grants.
//   The counter never wraps. Decrement occurs only from count>=2, and count==0 exists only outside RUN.
//   req_count is sampled only at accept; later changes have no effect on the running timer.
//   req_valid may drop before grant without penalty. Requesters hold valid until ready.
//   Reset asserted mid-RUN or mid-EXPIRE: immediate return to reset values; a pending expire is lost.
// TESTING
//   1. Reset, req_valid=4'b0001, req_count[0]=3, tick every cycle.
//      Expect ready[0] for 1 cycle, busy, expire[0] exactly 4 cycles after accept, then busy=0.
//   2. req_count[2]=0 -> expire[2] in the cycle after accept; no tick required.
//   3. All 4 requesting continuously, counts=2 -> grant order 0,1,2,3,0.
//      Expect one IDLE cycle between each EXPIRE and the next grant.
//   4. Owner 1, count=5, cancel[1] after 2 ticks -> busy drops next cycle and no expire[1].
//      cancel[3] asserted during that run -> no effect.
//   5. tick low for 20 cycles in RUN with count=2 -> count holds.
//      Then 2 ticks -> expire. Also check count=0xFFFF completes with no wrap.
//   6. Async rst_n low mid-RUN, asynchronous to clk -> all outputs are at reset values immediately.
//      After release, a new request is granted starting from rr_ptr=0.

Source files
------------

// File: rtl/riv_timer_sched.sv
// Round-robin owner of a single down-counting timer shared by NUM_REQ requesters.
// One grant at a time; the owner gets a one-cycle expire pulse or may cancel early.
module riv_timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CNT_W-1:0]     req_count,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           cancel,
  output logic [NUM_REQ-1:0]           expire,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   active_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EXPIRE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt, acc_count;
  logic [ID_W-1:0]  rr_ptr, gid;
  logic             found, accept, owner_cancel, last_tick;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Walk downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, k)]) begin
        found = 1'b1;
        gid   = wrap_add(rr_ptr, k);
      end
    end
  end

  assign accept       = found && (state == IDLE);
  assign acc_count    = req_count[int'(gid)*CNT_W +: CNT_W];
  assign owner_cancel = cancel[active_id];
  assign last_tick    = tick && (count == CNT_W'(1));

  // Gated by rst_n so no grant is advertised while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gid] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (accept) begin
          count_nxt = acc_count;
          state_nxt = (acc_count == '0) ? EXPIRE : RUN;
        end
      end
      RUN: begin
        if (owner_cancel) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (last_tick) begin
          state_nxt = EXPIRE;
          count_nxt = '0;
        end else if (tick) begin
          count_nxt = count - CNT_W'(1);
        end
      end
      EXPIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rr_ptr    <= '0;
      active_id <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (accept) begin
        active_id <= gid;
        rr_ptr    <= wrap_add(gid, 1);
      end
    end
  end

  // Pure decode of registered state, so the pulse cannot glitch.
  always_comb begin
    expire = '0;
    if (state == EXPIRE) expire[active_id] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_riv_timer_sched.sv
// Scoreboarded bench for riv_timer_sched: a behavioural model predicts grant and
// expire events, a negedge monitor matches them against what the DUT presents.
module tb_riv_timer_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  tick = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N*W-1:0]        req_count = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          cancel = '0;
  logic [N-1:0]          expire;
  logic                  busy;
  logic [$clog2(N)-1:0]  active_id;

  riv_timer_sched #(.NUM_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req_valid(req_valid),
    .req_count(req_count), .req_ready(req_ready), .cancel(cancel),
    .expire(expire), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int id; int cyc; } ev_t;  // kind 0 = grant, 1 = expire
  ev_t q[$];

  int tests = 0;
  int fails = 0;
  int cnt[N];
  bit cont[N];

  // Reference model: phase 0 idle, 1 timing, 2 expiring
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_rem = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int id, input int c);
    ev_t e;
    e.kind = kind; e.id = id; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_rem = 0;
    q.delete();
  endtask

  task automatic model_step(output int acc);
    int g;
    acc = -1;
    g = -1;
    case (m_phase)
      0: begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) begin
          acc = g;
          push_ev(0, g, cyc);
          m_owner = g;
          m_ptr = (g + 1) % N;
          m_rem = cnt[g];
          if (m_rem == 0) begin
            m_phase = 2;
            push_ev(1, g, cyc + 1);
          end else m_phase = 1;
        end
      end
      1: begin
        if (cancel[m_owner]) m_phase = 0;
        else if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_phase = 2;
            push_ev(1, m_owner, cyc + 1);
          end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // One clock cycle: inputs already set by the caller at posedge+1.
  task automatic step();
    int acc;
    for (int i = 0; i < N; i++) req_count[i*W +: W] = W'(cnt[i]);
    chk("busy", busy, m_phase != 0);
    chk("active_id", active_id, m_owner);
    model_step(acc);
    @(posedge clk);
    #1;
    if (acc >= 0 && !cont[acc]) req_valid[acc] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_ev(input int kind, input logic [N-1:0] v);
    int id;
    bit ok;
    id = 0;
    for (int i = 0; i < N; i++) if (v[i]) id = i;
    ok = ($countones(v) == 1) && (q.size() > 0) && (q[0].kind == kind) &&
         (q[0].id == id) && (q[0].cyc == cyc);
    tests++;
    if (!ok) begin
      fails++;
      if (q.size() > 0)
        $display("FAIL event: got kind=%0d bits=%b at cycle %0d, expected kind=%0d id=%0d at cycle %0d",
                 kind, v, cyc, q[0].kind, q[0].id, q[0].cyc);
      else
        $display("FAIL event: got kind=%0d bits=%b at cycle %0d, expected no event", kind, v, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) void'(q.pop_front());
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL missed_event: got nothing, expected kind=%0d id=%0d at cycle %0d",
                   q[0].kind, q[0].id, q[0].cyc);
          void'(q.pop_front());
        end
        if (|(req_valid & req_ready)) check_ev(0, req_valid & req_ready);
        if (|expire) check_ev(1, expire);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin cnt[i] = 0; cont[i] = 1'b0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_expire", expire, 0);
    chk("rst_active_id", active_id, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single request, count 3, tick every cycle
    tick = 1'b1; cnt[0] = 3; req_valid = 4'b0001;
    steps(8);

    // 2: zero count expires straight after accept, no tick needed
    tick = 1'b0; cnt[2] = 0; req_valid = 4'b0100;
    steps(4);

    // 3: all requesting continuously with count 2
    tick = 1'b1;
    for (int i = 0; i < N; i++) begin cnt[i] = 2; cont[i] = 1'b1; end
    req_valid = 4'b1111;
    steps(22);
    for (int i = 0; i < N; i++) cont[i] = 1'b0;
    req_valid = '0;
    steps(6);

    // 4: owner 1 cancels after 2 ticks; non-owner cancel ignored
    cnt[1] = 5; req_valid = 4'b0010;
    step();
    cancel = 4'b1000;
    steps(2);
    cancel = 4'b0010;
    step();
    cancel = '0;
    steps(4);

    // 5: tick low holds the count, then count 0xFFFF runs without wrap
    tick = 1'b0; cnt[0] = 2; req_valid = 4'b0001;
    steps(21);
    tick = 1'b1;
    steps(4);
    cnt[0] = 16'hFFFF; req_valid = 4'b0001;
    step();
    cnt[0] = 1;
    steps(65540);

    // 6: async reset mid-run, then grant restarts from pointer 0
    cnt[0] = 10; req_valid = 4'b0001;
    steps(4);
    req_valid = 4'b0011; cnt[1] = 1; cnt[0] = 2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    chk("async_expire", expire, 0);
    chk("async_active_id", active_id, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    steps(12);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          cnt[i] = $urandom_range(0, 5);
        end else if ($urandom_range(0, 7) == 0) cnt[i] = $urandom_range(0, 5);
      end
      tick = 1'(($urandom_range(0, 1)));
      cancel = '0;
      if ($urandom_range(0, 9) == 0) cancel[$urandom_range(0, N-1)] = 1'b1;
      step();
    end
    req_valid = '0; cancel = '0; tick = 1'b1;
    steps(12);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
